// File: rtl/pvr_raster_pkg.sv
// -----------------------------------------------------------------------------
// pvr_raster_pkg
// Shared constants and types for the tile raster walker.
//   TILE_DIM   - pixels per tile side (power of two, equals row-mask width)
//   COORD_W    - width of pixel-space coordinates
//   TILE_IDX_W - width of tile_x / tile_y indices
//   IDX_W      - width of an in-tile pixel offset (log2 TILE_DIM)
//   state_t    - walker FSM state encoding
// -----------------------------------------------------------------------------
package pvr_raster_pkg;

    localparam int TILE_DIM   = 32;
    localparam int COORD_W    = 11;
    localparam int TILE_IDX_W = 6;
    localparam int IDX_W      = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_EVAL = 2'd1,
        EMIT     = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/tile_raster_walker_if.sv
// -----------------------------------------------------------------------------
// tile_raster_walker_if
// Fragment stream from the raster walker to the shading/ISP stage.
//   frag_valid    - fragment available (master -> slave)
//   frag_ready    - downstream accepts (slave -> master)
//   frag_x/frag_y - pixel coordinates of the fragment
//   frag_row_last - last covered pixel of the current row
// -----------------------------------------------------------------------------
interface tile_raster_walker_if;
    import pvr_raster_pkg::*;

    logic               frag_valid;
    logic               frag_ready;
    logic [COORD_W-1:0] frag_x;
    logic [COORD_W-1:0] frag_y;
    logic               frag_row_last;

    modport master (
        output frag_valid,
        output frag_x,
        output frag_y,
        output frag_row_last,
        input  frag_ready
    );

    modport slave (
        input  frag_valid,
        input  frag_x,
        input  frag_y,
        input  frag_row_last,
        output frag_ready
    );

endinterface

// File: rtl/tile_raster_walker_lsb_pick32.sv
// -----------------------------------------------------------------------------
// lsb_pick32
// Combinational lowest-set-bit picker for a 32-bit coverage mask.
//   mask_in      - mask to inspect
//   lsb_idx      - index of the lowest set bit (0 when mask_in is 0)
//   is_single    - mask_in has exactly one bit set
//   mask_cleared - mask_in with its lowest set bit removed
// -----------------------------------------------------------------------------
module lsb_pick32 (
    input  logic [31:0] mask_in,
    output logic [4:0]  lsb_idx,
    output logic        is_single,
    output logic [31:0] mask_cleared
);

    // Scan from the top down so the last hit written is the lowest set bit.
    always_comb begin
        lsb_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mask_in[i]) begin
                lsb_idx = i[4:0];
            end
        end
    end

    // x & (x-1) drops the lowest set bit; a zero result on a nonzero input
    // means that bit was the only one.
    assign mask_cleared = mask_in & (mask_in - 32'd1);
    assign is_single    = (mask_in != 32'd0) && (mask_cleared == 32'd0);

endmodule

// File: rtl/tile_raster_walker.sv
// -----------------------------------------------------------------------------
// tile_raster_walker
// Walks one 32x32 tile row by row, presenting the row base coordinate to the
// edge-test logic and turning each returned coverage mask into a stream of
// one fragment per covered pixel. Empty rows cost a single cycle.
//   clock, reset        - system clock, asynchronous active-high reset
//   tile_start          - start pulse, honoured only while idle
//   tile_x, tile_y      - tile indices latched on an accepted start
//   busy, tile_done     - walk in progress / one-cycle completion pulse
//   x_ps, y_ps          - registered row base coordinate to the edge test
//   row_mask            - coverage of the row at (x_ps, y_ps), bit i = x_ps+i
//   frag                - fragment stream (valid/ready) to the pixel pipeline
// -----------------------------------------------------------------------------
module tile_raster_walker
    import pvr_raster_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tile_start,
    input  logic [TILE_IDX_W-1:0] tile_x,
    input  logic [TILE_IDX_W-1:0] tile_y,
    output logic                  busy,
    output logic                  tile_done,
    output logic [COORD_W-1:0]    x_ps,
    output logic [COORD_W-1:0]    y_ps,
    input  logic [TILE_DIM-1:0]   row_mask,
    tile_raster_walker_if.master  frag
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(TILE_DIM - 1);

    state_t                state_q,   state_d;
    logic [IDX_W-1:0]      y_off_q,   y_off_d;
    logic [TILE_DIM-1:0]   pending_q, pending_d;
    logic [COORD_W-1:0]    x_ps_q,    x_ps_d;
    logic [COORD_W-1:0]    y_ps_q,    y_ps_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_single;
    logic [TILE_DIM-1:0]   pick_rest;
    logic                  in_emit;

    lsb_pick32 u_pick (
        .mask_in      (pending_q),
        .lsb_idx      (pick_idx),
        .is_single    (pick_single),
        .mask_cleared (pick_rest)
    );

    // State and datapath registers. x_ps_q doubles as the tile base x and
    // y_ps_q always equals base_y + y_off, so fragments reuse them directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            y_off_q   <= '0;
            pending_q <= '0;
            x_ps_q    <= '0;
            y_ps_q    <= '0;
        end else begin
            state_q   <= state_d;
            y_off_q   <= y_off_d;
            pending_q <= pending_d;
            x_ps_q    <= x_ps_d;
            y_ps_q    <= y_ps_d;
        end
    end

    // Next-state logic. Leaving a row (empty in ROW_EVAL, or its last
    // fragment accepted in EMIT) either finishes the tile on the last row or
    // advances y_off and y_ps together.
    always_comb begin
        state_d   = state_q;
        y_off_d   = y_off_q;
        pending_d = pending_q;
        x_ps_d    = x_ps_q;
        y_ps_d    = y_ps_q;

        case (state_q)
            IDLE: begin
                if (tile_start) begin
                    x_ps_d    = {tile_x, IDX_W'(0)};
                    y_ps_d    = {tile_y, IDX_W'(0)};
                    y_off_d   = '0;
                    pending_d = '0;
                    state_d   = ROW_EVAL;
                end
            end
            ROW_EVAL: begin
                if (row_mask == '0) begin
                    if (y_off_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        y_off_d = y_off_q + IDX_W'(1);
                        y_ps_d  = y_ps_q + COORD_W'(1);
                    end
                end else begin
                    pending_d = row_mask;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (frag.frag_ready) begin
                    pending_d = pick_rest;
                    if (pick_single) begin
                        if (y_off_q == LAST_ROW) begin
                            state_d = DONE;
                        end else begin
                            y_off_d = y_off_q + IDX_W'(1);
                            y_ps_d  = y_ps_q + COORD_W'(1);
                            state_d = ROW_EVAL;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fragment outputs are a pure function of the registered pending mask,
    // so they hold steady for as long as the consumer stalls.
    assign in_emit            = (state_q == EMIT);
    assign frag.frag_valid    = in_emit;
    assign frag.frag_x        = in_emit ? (x_ps_q + COORD_W'(pick_idx)) : '0;
    assign frag.frag_y        = in_emit ? y_ps_q : '0;
    assign frag.frag_row_last = in_emit && pick_single;

    assign busy      = (state_q != IDLE);
    assign tile_done = (state_q == DONE);
    assign x_ps      = x_ps_q;
    assign y_ps      = y_ps_q;

endmodule

// File: tb/tb_tile_raster_walker.sv
// -----------------------------------------------------------------------------
// tb_tile_raster_walker
// Directed bench for tile_raster_walker. Each test pushes its hand-computed
// fragments into a scoreboard queue; a negedge monitor pops and compares on
// every accepted fragment, checks stall stability and tile_done timing.
// -----------------------------------------------------------------------------
module tb_tile_raster_walker;
    import pvr_raster_pkg::*;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               last;
    } frag_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  tile_start = 1'b0;
    logic [TILE_IDX_W-1:0] tile_x = '0;
    logic [TILE_IDX_W-1:0] tile_y = '0;
    logic                  busy;
    logic                  tile_done;
    logic [COORD_W-1:0]    x_ps;
    logic [COORD_W-1:0]    y_ps;
    logic [TILE_DIM-1:0]   row_mask;
    logic                  frag_ready = 1'b1;

    logic                  mask_all = 1'b0;
    logic [COORD_W-1:0]    mask_y = '0;
    logic [TILE_DIM-1:0]   mask_val = '0;
    logic                  toggle_ready = 1'b0;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    done_count = 0;
    int    done_rel = 0;
    int    frag_seen = 0;
    int    pc;
    frag_t exp_q[$];
    int    accept_rel[$];

    tile_raster_walker_if frag_bus ();
    assign frag_bus.frag_ready = frag_ready;

    tile_raster_walker dut (
        .clock      (clock),
        .reset      (reset),
        .tile_start (tile_start),
        .tile_x     (tile_x),
        .tile_y     (tile_y),
        .busy       (busy),
        .tile_done  (tile_done),
        .x_ps       (x_ps),
        .y_ps       (y_ps),
        .row_mask   (row_mask),
        .frag       (frag_bus.master)
    );

    // 10 ns system clock.
    always #5 clock = ~clock;

    // Edge-test model: either every row is covered by mask_val, or only the
    // row whose y_ps equals mask_y.
    always_comb begin
        row_mask = '0;
        if (mask_all || (y_ps == mask_y)) begin
            row_mask = mask_val;
        end
    end

    // Backpressure driver: flips frag_ready every cycle while enabled.
    always @(posedge clock) begin
        if (toggle_ready) begin
            #1 frag_ready = ~frag_ready;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Presents a one-cycle start pulse and records the accepting edge.
    task automatic applyStimulus(input logic [TILE_IDX_W-1:0] tx,
                                 input logic [TILE_IDX_W-1:0] ty);
        @(posedge clock);
        #1;
        tile_x     = tx;
        tile_y     = ty;
        tile_start = 1'b1;
        @(posedge clock);
        start_cyc = cyc;
        accept_rel.delete();
        #1 tile_start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic waitDone(input int prev_count, input int exp_rel, input string name);
        int n = 0;
        while (done_count == prev_count && n < 3000) begin
            @(posedge clock);
            n++;
        end
        if (done_count == prev_count) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s no tile_done within %0d cycles, required one", name, n);
        end else if (exp_rel >= 0) begin
            checkOutput(name, 32'(done_rel), 32'(exp_rel));
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    // Monitor: cycle counting, scoreboard pops on handshakes, stall
    // stability, and tile_done / busy relationship.
    always @(negedge clock) begin
        int    rel;
        frag_t exp_f;
        logic  held_prev;
        frag_t held;
        logic  done_prev;
        cyc = cyc + 1;
        rel = cyc - start_cyc;

        if (frag_bus.frag_valid) begin
            if (held_prev) begin
                checkOutput("hold_x", 32'(frag_bus.frag_x), 32'(held.x));
                checkOutput("hold_y", 32'(frag_bus.frag_y), 32'(held.y));
                checkOutput("hold_last", 32'(frag_bus.frag_row_last), 32'(held.last));
            end
            if (frag_ready) begin
                frag_seen++;
                accept_rel.push_back(rel);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_frag actual=(%0d,%0d) required=none",
                             frag_bus.frag_x, frag_bus.frag_y);
                end else begin
                    exp_f = exp_q.pop_front();
                    checkOutput("frag_x", 32'(frag_bus.frag_x), 32'(exp_f.x));
                    checkOutput("frag_y", 32'(frag_bus.frag_y), 32'(exp_f.y));
                    checkOutput("frag_row_last", 32'(frag_bus.frag_row_last), 32'(exp_f.last));
                end
            end
        end
        held_prev = frag_bus.frag_valid && !frag_ready;
        held      = {frag_bus.frag_x, frag_bus.frag_y, frag_bus.frag_row_last};

        if (done_prev) begin
            checkOutput("busy_after_done", 32'(busy), 32'd0);
        end
        if (tile_done) begin
            done_count++;
            done_rel = rel;
            checkOutput("busy_in_done", 32'(busy), 32'd1);
        end
        done_prev = tile_done;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state.
        #3;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(tile_done), 32'd0);
        checkOutput("rst_valid", 32'(frag_bus.frag_valid), 32'd0);
        checkOutput("rst_last", 32'(frag_bus.frag_row_last), 32'd0);
        checkOutput("rst_x_ps", 32'(x_ps), 32'd0);
        checkOutput("rst_y_ps", 32'(y_ps), 32'd0);
        checkOutput("rst_frag_x", 32'(frag_bus.frag_x), 32'd0);
        checkOutput("rst_frag_y", 32'(frag_bus.frag_y), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset in the middle of a stalled EMIT.
        $display("[TB] test: reset mid-EMIT");
        mask_all   = 1'b1;
        mask_val   = 32'h0000_000F;
        frag_ready = 1'b0;
        pc = done_count;
        applyStimulus(6'd2, 6'd3);
        repeat (2) @(negedge clock);
        #1;
        checkOutput("pre_reset_valid", 32'(frag_bus.frag_valid), 32'd1);
        checkOutput("pre_reset_x", 32'(frag_bus.frag_x), 32'd64);
        checkOutput("pre_reset_y", 32'(frag_bus.frag_y), 32'd96);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid_reset_valid", 32'(frag_bus.frag_valid), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_x_ps", 32'(x_ps), 32'd0);
        checkOutput("mid_reset_y_ps", 32'(y_ps), 32'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        mask_all   = 1'b0;
        mask_val   = '0;
        frag_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("no_done_after_reset", 32'(done_count), 32'(pc));

        // Empty tile (1,1): y_ps walks 32..63, done on cycle 33.
        $display("[TB] test: empty tile");
        pc = done_count;
        applyStimulus(6'd1, 6'd1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clock);
            #1;
            checkOutput("empty_y_ps", 32'(y_ps), 32'(32 + k));
            if (k == 0) begin
                checkOutput("empty_x_ps", 32'(x_ps), 32'd32);
            end
        end
        waitDone(pc, 33, "empty_done_cycle");

        // Single covered row at y=5 in tile (0,0).
        $display("[TB] test: single row");
        mask_y   = 11'd5;
        mask_val = 32'h8000_0001;
        exp_q.push_back('{x: 11'd0,  y: 11'd5, last: 1'b0});
        exp_q.push_back('{x: 11'd31, y: 11'd5, last: 1'b1});
        pc = done_count;
        applyStimulus(6'd0, 6'd0);
        waitDone(pc, 35, "single_done_cycle");
        checkOutput("single_accepts", 32'(accept_rel.size()), 32'd2);
        if (accept_rel.size() == 2) begin
            checkOutput("single_first_cycle", 32'(accept_rel[0]), 32'd7);
            checkOutput("single_second_cycle", 32'(accept_rel[1]), 32'd8);
        end

        // Backpressure on tile (4,2), mask 0x6 on the first row.
        $display("[TB] test: backpressure");
        mask_y     = 11'd64;
        mask_val   = 32'h0000_0006;
        exp_q.push_back('{x: 11'd129, y: 11'd64, last: 1'b0});
        exp_q.push_back('{x: 11'd130, y: 11'd64, last: 1'b1});
        frag_ready = 1'b0;
        pc = done_count;
        toggle_ready = 1'b1;
        applyStimulus(6'd4, 6'd2);
        waitDone(pc, -1, "bp_done");
        toggle_ready = 1'b0;
        #2 frag_ready = 1'b1;
        checkOutput("bp_accepts", 32'(accept_rel.size()), 32'd2);

        // Full tile (63,63) with a stray start pulse mid-walk.
        $display("[TB] test: full tile");
        mask_all = 1'b1;
        mask_val = 32'hFFFF_FFFF;
        for (int r = 0; r < 32; r++) begin
            for (int i = 0; i < 32; i++) begin
                exp_q.push_back('{x: COORD_W'(2016 + i), y: COORD_W'(2016 + r),
                                  last: (i == 31)});
            end
        end
        pc = done_count;
        applyStimulus(6'd63, 6'd63);
        repeat (200) @(posedge clock);
        #1;
        tile_x     = 6'd0;
        tile_y     = 6'd0;
        tile_start = 1'b1;
        @(posedge clock);
        #1 tile_start = 1'b0;
        waitDone(pc, 1057, "full_done_cycle");
        checkOutput("full_accepts", 32'(accept_rel.size()), 32'd1024);
        mask_all = 1'b0;
        mask_val = '0;

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("frag_total", 32'(frag_seen), 32'd1028);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
